// File: rtl/ysyx_22041412_lsu_pkg.sv
// ysyx_22041412_lsu_pkg
//   Shared types and constants for the NPC load/store unit.
//   - lsu_state_e : FSM state encoding
//   - FAULT_*     : response fault codes
//   - LB..LWU, SB..SD : RISC-V funct3 size/sign codes
package ysyx_22041412_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_NULL     = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

endpackage

// File: rtl/ysyx_22041412_lsu_chk.sv
// ysyx_22041412_lsu_chk
//   Combinational pre-issue legality checker for one LSU request.
//   Ports: wen (1=store), func3, addr in; fault code out.
//   Priority: null address, then illegal funct3, then misalignment.
//   Misalignment is only detected when YSYX_22041412_LSU_ALIGN_CHECK_EN
//   is defined; otherwise unaligned accesses pass through to memory.
module ysyx_22041412_lsu_chk
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  wen,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [1:0]            fault
);

  logic legal_f3;
  logic misalign;

  always_comb begin
    legal_f3 = wen ? (func3 inside {SB, SH, SW, SD})
                   : (func3 inside {LB, LH, LW, LD, LBU, LHU, LWU});
`ifdef YSYX_22041412_LSU_ALIGN_CHECK_EN
    // Low-bit mask of the access size; 1<<3 truncates to 0 in 3 bits,
    // so the subtraction still yields 3'b111 for doublewords.
    misalign = |(addr[2:0] & ((3'b001 << func3[1:0]) - 3'b001));
`else
    misalign = 1'b0;
`endif
    if (addr == '0)     fault = FAULT_NULL;
    else if (!legal_f3) fault = FAULT_MISALIGN;
    else if (misalign)  fault = FAULT_MISALIGN;
    else                fault = FAULT_NONE;
  end

endmodule

// File: rtl/ysyx_22041412_lsu.sv
// ysyx_22041412_lsu
//   Memory-stage load/store unit: single outstanding request, drives the
//   data-memory port, waits out mem_stall with a watchdog, returns a
//   response (rdata, rd, fault) to WB.
//   Ports: clk/rst (sync, active-high); req_* EX handshake in;
//   resp_* WB handshake out; mem_* memory port (registered outputs).
//   Optional macro: YSYX_22041412_LSU_ALIGN_CHECK_EN (alignment fault).
module ysyx_22041412_lsu
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [4:0]            resp_rd,
  output logic [1:0]            resp_fault,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [2:0]            mem_func3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_stall,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]            resp_rd_q, resp_rd_d;
  logic [1:0]            resp_fault_q, resp_fault_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [2:0]            mem_func3_q, mem_func3_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0] chk_fault;
  logic       acc_tout, acc_done;

  ysyx_22041412_lsu_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
    .wen   (req_wen),
    .func3 (req_func3),
    .addr  (req_addr),
    .fault (chk_fault)
  );

  // Stall=0 with wait_cnt==0 is ignored: it may be the ready flag left
  // over from the previous access rather than this one completing.
  always_comb begin
    acc_tout = mem_stall && (wait_cnt_q == CNT_MAX);
    acc_done = !mem_stall && (wait_cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_fault_q <= FAULT_NONE;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_func3_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_fault_q <= resp_fault_d;
      mem_en_q     <= mem_en_d;
      mem_wen_q    <= mem_wen_d;
      mem_func3_q  <= mem_func3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = (chk_fault == FAULT_NONE) ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (acc_tout || acc_done) state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_fault_d = resp_fault_q;
    mem_en_d     = mem_en_q;
    mem_wen_d    = mem_wen_q;
    mem_func3_d  = mem_func3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        // rd is parked in the response register from accept onwards.
        resp_rd_d = req_rd;
        if (chk_fault != FAULT_NONE) begin
          resp_valid_d = 1'b1;
          resp_fault_d = chk_fault;
          resp_rdata_d = '0;
        end else begin
          mem_en_d    = 1'b1;
          mem_wen_d   = req_wen;
          mem_func3_d = req_func3;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          wait_cnt_d  = '0;
        end
      end
      ST_ACCESS: begin
        if (acc_tout || acc_done) begin
          // Drop the port in the same edge so the access is not re-issued.
          mem_en_d     = 1'b0;
          mem_wen_d    = 1'b0;
          mem_func3_d  = '0;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          resp_valid_d = 1'b1;
          resp_fault_d = acc_tout ? FAULT_TIMEOUT : FAULT_NONE;
          resp_rdata_d = (acc_tout || mem_wen_q) ? '0 : mem_rdata;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: if (resp_ready) resp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_fault = resp_fault_q;
  assign mem_en     = mem_en_q;
  assign mem_wen    = mem_wen_q;
  assign mem_func3  = mem_func3_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Bench for ysyx_22041412_lsu: directed table, reset corner sequences,
// and randomized requests checked against a latency/fault model.
module tb_ysyx_22041412_lsu;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_fault;
  logic        mem_en, mem_wen;
  logic [2:0]  mem_func3;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_stall = 1'b0;
  logic [63:0] mem_rdata = '0;

  always #5 clk = ~clk;

  ysyx_22041412_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_fault(resp_fault),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    int          lat;     // memory busy cycles after mem_en rises
    logic [63:0] mdata;
    int          hold;    // cycles WB holds resp_ready low
    logic [1:0]  ex_fault;
    int          ex_lat;  // accept edge -> first cycle resp_valid seen
    int          ex_en;   // cycles mem_en is high
    logic [63:0] ex_rdata;
  } vec_t;

  int checks = 0, failures = 0;
  int mem_lat = 0, en_cnt = 0;
  logic [63:0] mem_data = '0;

  // Memory: busy for mem_lat cycles of mem_en, then ready with data.
  // Idle memory reports stall=0, mimicking a leftover ready flag.
  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      mem_stall = (en_cnt < mem_lat);
      mem_rdata = mem_stall ? {$urandom, $urandom} : mem_data;
      en_cnt++;
    end else begin
      en_cnt    = 0;
      mem_stall = 1'b0;
      mem_rdata = {$urandom, $urandom};
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [4:0] rd, input int lat,
                               input logic [63:0] mdata, input int hold, input logic [1:0] ef,
                               input int el, input int een, input logic [63:0] erd);
    vec_t v;
    v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.lat = lat;
    v.mdata = mdata; v.hold = hold; v.ex_fault = ef; v.ex_lat = el; v.ex_en = een;
    v.ex_rdata = erd;
    return v;
  endfunction

  // Reference: outcome from the request rules and memory latency alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int s;
    r = v;
    r.ex_rdata = '0; r.ex_lat = 1; r.ex_en = 0;
    if (v.addr == 0) r.ex_fault = 2'b10;
    else if (v.wen ? (v.f3 > 3) : (v.f3 == 7)) r.ex_fault = 2'b01;
`ifdef YSYX_22041412_LSU_ALIGN_CHECK_EN
    else if (v.addr % (64'd1 << v.f3[1:0]) != 0) r.ex_fault = 2'b01;
`endif
    else if (v.lat > TO) begin
      r.ex_fault = 2'b11; r.ex_lat = TO + 2; r.ex_en = TO + 1;
    end else begin
      s = (v.lat == 0) ? 1 : v.lat;
      r.ex_fault = 2'b00; r.ex_lat = s + 2; r.ex_en = s + 1;
      r.ex_rdata = v.wen ? 64'd0 : v.mdata;
    end
    return r;
  endfunction

  task automatic run(input vec_t v, input string nm);
    int n, en, bad, hbad;
    bit seen;
    logic [63:0] s_rdata;
    logic [4:0]  s_rd;
    logic [1:0]  s_fault;
    @(negedge clk);
    mem_lat = v.lat; mem_data = v.mdata;
    req_wen = v.wen; req_func3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_rd = v.rd; req_valid = 1'b1; resp_ready = 1'b0;
    chk({nm, " req_ready"}, req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0; en = 0; bad = 0; seen = 0;
    while (!seen && n < TO + 30) begin
      @(negedge clk);
      n++;
      if (mem_en) begin
        en++;
        if (mem_wen !== v.wen || mem_func3 !== v.f3 || mem_addr !== v.addr ||
            mem_wdata !== v.wdata) bad++;
      end
      if (resp_valid) seen = 1;
    end
    chk({nm, " resp_seen"}, seen, 1);
    chk({nm, " latency"}, n, v.ex_lat);
    chk({nm, " en_cycles"}, en, v.ex_en);
    chk({nm, " mem_fields"}, bad, 0);
    chk({nm, " fault"}, resp_fault, v.ex_fault);
    chk({nm, " rdata"}, resp_rdata, v.ex_rdata);
    chk({nm, " rd"}, resp_rd, v.rd);
    chk({nm, " port_idle"}, {mem_en, mem_addr}, 0);
    s_rdata = resp_rdata; s_rd = resp_rd; s_fault = resp_fault; hbad = 0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== s_rdata || resp_rd !== s_rd ||
          resp_fault !== s_fault || mem_en !== 1'b0 || req_ready !== 1'b0) hbad++;
    end
    if (v.hold > 0) chk({nm, " hold_stable"}, hbad, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, " released"}, {resp_valid, req_ready}, 2'b01);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0] = mkv(0, 3'b010, 64'h8000_0004, 64'h0, 5, 1, 64'hFFFF_FFFF_8000_0000, 0,
                 2'b00, 3, 2, 64'hFFFF_FFFF_8000_0000);
    tbl[1] = mkv(1, 3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, 1, 64'hABCD, 0,
                 2'b00, 3, 2, 64'h0);
    tbl[2] = mkv(0, 3'b011, 64'h0, 64'h0, 7, 1, 64'h55, 0, 2'b10, 1, 0, 64'h0);
`ifdef YSYX_22041412_LSU_ALIGN_CHECK_EN
    tbl[3] = mkv(0, 3'b010, 64'h8000_0002, 64'h0, 9, 1, 64'h1234, 0, 2'b01, 1, 0, 64'h0);
`else
    tbl[3] = mkv(0, 3'b010, 64'h8000_0002, 64'h0, 9, 1, 64'h1234, 0, 2'b00, 3, 2, 64'h1234);
`endif
    tbl[4] = mkv(1, 3'b100, 64'h8000_0000, 64'h77, 3, 1, 64'h0, 0, 2'b01, 1, 0, 64'h0);
    tbl[5] = mkv(0, 3'b111, 64'h8000_0000, 64'h0, 4, 1, 64'h99, 0, 2'b01, 1, 0, 64'h0);
    tbl[6] = mkv(0, 3'b100, 64'h8000_0021, 64'h0, 11, 0, 64'hFF, 0, 2'b00, 3, 2, 64'hFF);
    tbl[7] = mkv(0, 3'b011, 64'h8000_0100, 64'h0, 12, TO, 64'hCAFE_F00D, 0,
                 2'b00, TO + 2, TO + 1, 64'hCAFE_F00D);
    tbl[8] = mkv(0, 3'b011, 64'h8000_0108, 64'h0, 13, TO + 1, 64'hBEEF, 0,
                 2'b11, TO + 2, TO + 1, 64'h0);
    tbl[9] = mkv(0, 3'b001, 64'h8000_0200, 64'h0, 31, 4, 64'hFFFF_FFFF_FFFF_8001, 5,
                 2'b00, 6, 5, 64'hFFFF_FFFF_FFFF_8001);
    tbl[10] = mkv(1, 3'b101, 64'h0, 64'h1, 1, 1, 64'h0, 0, 2'b10, 1, 0, 64'h0);
    tbl[11] = mkv(1, 3'b000, 64'h8000_0303, 64'hA5, 2, 2, 64'h0, 5, 2'b00, 4, 3, 64'h0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst req_ready", req_ready, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst resp_rd_fault", {resp_rd, resp_fault}, 0);
    chk("rst mem_en_wen", {mem_en, mem_wen, mem_func3}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle req_ready", req_ready, 1);

    foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i));

    // Reset pulsed in the ACCESS cycle.
    @(negedge clk);
    mem_lat = 3; req_wen = 0; req_func3 = 3'b011; req_addr = 64'h8000_0400; req_rd = 6;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstacc mem_en_before", mem_en, 1);
    rst = 1'b1;
    #1 chk("rstacc req_ready_in_rst", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstacc mem_en_after", mem_en, 0);
    chk("rstacc resp_valid_after", resp_valid, 0);
    chk("rstacc mem_addr_after", mem_addr, 0);
    #1 chk("rstacc req_ready_after", req_ready, 1);

    // Reset pulsed while a response is pending.
    @(negedge clk);
    req_addr = 64'h0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstresp valid_before", resp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstresp valid_after", resp_valid, 0);
    chk("rstresp mem_en_after", mem_en, 0);

    // Randomized requests against the model.
    for (int k = 0; k < 40; k++) begin
      int r;
      rv.wen = 1'($urandom_range(0, 1));
      rv.f3 = 3'($urandom_range(0, 7));
      rv.addr = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      if (r == 0) rv.addr = 64'h0;
      else if (r < 5) rv.addr = rv.addr & ~64'h7;
      rv.wdata = {$urandom, $urandom};
      rv.rd = 5'($urandom_range(0, 31));
      rv.lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3)
                                             : $urandom_range(0, 4);
      rv.mdata = {$urandom, $urandom};
      rv.hold = $urandom_range(0, 3);
      run(model(rv), $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_lsu.md
# ysyx_22041412_lsu

Load/store unit for the NPC memory stage: the initiator side of the data-memory port. Accepts one load/store request at a time from the EX stage via a valid/ready handshake and drives the memory's `en`/`wen`/`func3`/`addr`/`wdata` port. It waits out `stall`, captures the already-extended read data, and returns a response (data, destination register, fault code) to WB via a second valid/ready handshake. It adds address checks and a stall watchdog so a hung or illegal access never deadlocks the pipeline.

## Interface
- `ADDR_WIDTH`, 64, request/memory address width
- `DATA_WIDTH`, 64, data width
- `TIMEOUT_CYCLES`, 255, maximum stalled cycles before timeout fault; >=2
- `clk` in 1: sole clock
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: EX request valid
- `req_ready` out 1: LSU can accept a request
- `req_wen` in 1: 1 = store, 0 = load
- `req_func3` in 3: RISC-V funct3 (size/sign)
- `req_addr` in ADDR_WIDTH: byte address
- `req_wdata` in DATA_WIDTH: store data, LSB-aligned
- `req_rd` in 5: load destination register
- `resp_valid` out 1: response valid
- `resp_ready` in 1: WB accepts the response
- `resp_rdata` out DATA_WIDTH: load result; 0 for stores and faults
- `resp_rd` out 5: echoed `req_rd`
- `resp_fault` out 2: 00 ok, 01 misaligned/illegal, 10 null address, 11 timeout
- `mem_en` out 1: memory enable
- `mem_wen` out 1: memory write enable
- `mem_func3` out 3: memory size/sign code
- `mem_addr` out ADDR_WIDTH: memory address; 0 when idle
- `mem_wdata` out DATA_WIDTH: memory write data
- `mem_stall` in 1: memory busy; low once data is ready
- `mem_rdata` in DATA_WIDTH: extended read data, valid in the cycle `mem_stall` falls

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1. On `req_valid`, latch `wen`, `func3`, `addr`, `wdata`, and `rd`, then run the checks.
  - `addr`==0 -> RESP with fault 10. Memory treats address 0 as idle, so the access is never issued.
  - Store with `func3[2]`=1, or load with `func3`=111 -> RESP with fault 01.
  - Misaligned access (`addr & ((1<<func3[1:0])-1)` != 0) -> RESP with fault 01; only checked when the macro is defined.
  - Otherwise -> ACCESS, and clear `wait_cnt`.
- **ACCESS**
  - Drive `mem_en`=1, `mem_wen`=latched `wen`, and latched `func3`/`addr`/`wdata`. All are registered outputs.
  - If `mem_stall`=1: increment `wait_cnt`. If `wait_cnt`==TIMEOUT_CYCLES, go to RESP with fault 11.
  - If `mem_stall`=0 and `wait_cnt`!=0: capture `mem_rdata` (loads only; stores capture 0), fault 00, go to RESP.
  - If `mem_stall`=0 and `wait_cnt`==0: treat as not yet started and count as a stall cycle. This rejects leftover ready from a previous access.
- **RESP**
  - `resp_valid`=1; `mem_*` all 0.
  - Hold all response outputs stable until `resp_ready`, then go to IDLE.
- `req_ready` is 0 outside IDLE. There is no request queueing, so at least one IDLE cycle separates memory accesses. This guarantees the memory's ready flag clears before the next `en`.
- Fault responses zero `resp_rdata` and still echo `resp_rd`.

## Timing
- Reset values: state IDLE; `req_ready` 0 while `rst`=1; `resp_valid` 0; `resp_rdata` 0; `resp_rd` 0; `resp_fault` 00; all `mem_*` 0; `wait_cnt` 0.
- Nominal access sequence:
  - Cycle 0: request accepted.
  - Cycle 1: `mem_en`=1, `mem_stall`=1.
  - Cycle 2: `mem_stall`=0, data captured.
  - Cycle 3: `resp_valid`=1, `mem_en`=0.
- Nominal latency is 3 cycles from accept to response. Each extra stall cycle adds 1.
- `mem_en` must drop in the cycle after `mem_stall` falls. Holding it one more cycle would re-issue the access.
- Pre-issue faults (01, 10): `resp_valid` is asserted 1 cycle after accept; the memory is untouched.
- Timeout fault: `resp_valid` is asserted TIMEOUT_CYCLES+1 cycles after `mem_en` rises.
- `wait_cnt` width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
- Reset mid-ACCESS or mid-RESP: return to IDLE on that edge; `mem_en` and `resp_valid` are low the next cycle; the in-flight request is discarded.
- A response stalled by WB (`resp_ready`=0) never blocks memory: `mem_en` is already low.

## Configuration
- `YSYX_22041412_LSU_ALIGN_CHECK_EN`
  - Defined: misaligned loads/stores return fault 01 without issuing.
  - Undefined: the alignment check is removed, misaligned addresses are issued unchanged, and fault 01 arises only from illegal `func3`.

## Structure
- Package `ysyx_22041412_lsu_pkg` holds:
  - the state enum;
  - the fault-code constants (`FAULT_NONE`/`MISALIGN`/`NULL`/`TIMEOUT`);
  - the funct3 constants (`LB`..`LWU`, `SB`..`SD`).
- Sub-module `ysyx_22041412_lsu_chk` is the combinational legality/alignment checker. It takes `wen`, `func3`, and `addr`, and outputs the fault code. It contains the macro-guarded alignment logic.
- The FSM, watchdog, and output registers live in the top module.

## Test plan
- Load `lw` from 0x80000004, memory returns 0xFFFFFFFF_80000000 -> `resp_valid` 3 cycles after accept, `resp_rdata`=0xFFFFFFFF_80000000, `resp_rd` echoed, fault 00.
- Store `sd` to 0x80000010 with data 0x1122334455667788 -> `mem_en`/`mem_wen` high exactly 2 cycles with `mem_wdata` stable, `resp_rdata`=0, fault 00, no second write.
- Load to address 0 -> fault 10 after 1 cycle, `mem_en` never asserted.
- `lw` at 0x80000002 -> fault 01 with the macro defined; issued normally with the macro undefined.
- `mem_stall` held high -> fault 11 after TIMEOUT_CYCLES+1 cycles; then `mem_en` is low and the next request is accepted.
- `rst` pulsed in the ACCESS cycle, and `resp_ready` held low 5 cycles in RESP -> after reset, state IDLE with `mem_en`=0; in RESP, outputs stable until `resp_ready`.
